bcd_cascade_counter: RTL and testbench
======================================

Name: bcd_cascade_counter

Overview:
Parametrised multi-digit modulo-N counter, next generation of the single-digit decade counter. It counts up or down across DIGITS cascaded digits with an internal ripple-free carry/borrow chain. It supports synchronous clear, parallel load and wrap or saturate mode. It drives the daughterboard 7-segment/LED displays, and its lookahead terminal-count output cascades into further instances.

Parameters:
DIGITS, 4, number of cascaded digits (1..8)
MODULUS, 10, count base per digit (2..16); each digit ranges 0..MODULUS-1
WRAP, 1, 1 = roll over at terminal value; 0 = saturate at terminal value

Ports:
clk  input  1  system clock, all state on rising edge
rst  input  1  asynchronous active-low reset
en  input  1  count enable; one step per clk while high
up  input  1  direction: 1 = increment, 0 = decrement
clr  input  1  synchronous clear to zero
load  input  1  synchronous parallel load
load_val  input  4*DIGITS  load value, digit i in bits [4i+3:4i], digit 0 least significant
cnt  output  4*DIGITS  current count, same packing as load_val
carry  output  1  registered one-cycle pulse: up-count wrapped from all-max to zero
borrow  output  1  registered one-cycle pulse: down-count wrapped from zero to all-max
tc  output  1  combinational lookahead: en & (up ? all digits == MODULUS-1 : all digits == 0)
sat  output  1  registered; high while held at terminal value in WRAP=0 mode

Behaviour:
- Reset (rst low, asynchronous): cnt = 0, carry = 0, borrow = 0, sat = 0. Release is synchronous to clk via the normal edge.
- Per-edge priority: clr > load > en. With none asserted, the counter holds and carry/borrow are 0.
- clr: cnt <= 0, carry <= 0, borrow <= 0, sat <= 0.
- load: each digit <= load_val digit if < MODULUS, else 0 (per digit, independently). carry/borrow <= 0. sat <= 0.
- en, up=1: digit 0 increments.
  - Digit i increments only when all lower digits == MODULUS-1.
  - A digit at MODULUS-1 receiving an increment goes to 0.
- en, up=0: digit 0 decrements.
  - Digit i decrements only when all lower digits == 0.
  - A digit at 0 receiving a decrement goes to MODULUS-1.
- Full-range wrap, WRAP=1:
  - Up from all digits == MODULUS-1: cnt <= 0 and carry <= 1 on the same edge; carry lasts exactly one cycle unless wrap repeats.
  - Down from all digits == 0: cnt <= all MODULUS-1 and borrow <= 1 on the same edge.
- Full-range terminal, WRAP=0:
  - At the terminal value in the requested direction, cnt holds, carry/borrow stay 0, and sat <= 1.
  - sat clears on the first edge where the counter moves (opposite direction), or on clr or load.
- Direction change mid-count is legal. The new direction applies on the next enabled edge, with no extra latency.
- tc is purely combinational from cnt, en and up. It is asserted regardless of WRAP. It feeds the next instance's en for cascading.
- Latency: cnt updates one edge after the qualifying input. carry/borrow/sat assert on that same edge.
- Digit arithmetic is 4-bit. Values >= MODULUS are unreachable except via rejected loads, which map to 0.
- Asynchronous reset mid-count overrides everything immediately.

Test Plan:
- Reset: hold rst low 3 cycles with en=1 -> cnt=0x0000, carry=borrow=sat=0. Release rst, en=1, up=1, 12 edges -> cnt=0x0012.
- Up wrap, DIGITS=4, MODULUS=10, WRAP=1: load 0x9998, en=1, up=1.
  - After 1 edge: cnt=0x9999, tc=1.
  - After 2 edges: cnt=0x0000, carry=1 for exactly one cycle.
  - After 3 edges: cnt=0x0001.
- Down wrap: load 0x0001, up=0, en=1.
  - After 1 edge: cnt=0x0000, tc=1.
  - After 2 edges: cnt=0x9999, borrow=1 for one cycle.
- Saturate, WRAP=0: load 0x9999, up=1, en=1, 3 edges -> cnt=0x9999, carry=0, sat=1. Then up=0, 1 edge -> cnt=0x9998, sat=0.
- Priority and load sanitisation:
  - clr=load=en=1 together -> cnt=0.
  - load=1 with load_val=0x1A3F (MODULUS=10) -> cnt=0x1030.
  - MODULUS=16, load 0xFFFF, up=1, en=1 -> cnt=0x0000, carry=1.
- Async reset mid-count: while counting at 0x0457, assert rst between edges -> cnt=0 immediately, before the next clk edge. carry stays 0.

Source files
------------

// File: rtl/bcd_cascade_counter.sv
// Multi-digit modulo-N up/down counter with lookahead terminal count.
// Supports wrap-around or saturation at the full-range terminal value.
module bcd_cascade_counter #(
  parameter int DIGITS  = 4,
  parameter int MODULUS = 10,
  parameter bit WRAP    = 1'b1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  en,
  input  logic                  up,
  input  logic                  clr,
  input  logic                  load,
  input  logic [4*DIGITS-1:0]   load_val,
  output logic [4*DIGITS-1:0]   cnt,
  output logic                  carry,
  output logic                  borrow,
  output logic                  tc,
  output logic                  sat
);

  localparam logic [3:0] DMAX = 4'(MODULUS - 1);
  localparam logic [4:0] MODW = 5'(MODULUS);

  logic [3:0]        r_dig [DIGITS];
  logic [3:0]        w_dig_nxt [DIGITS];
  logic [3:0]        w_ld_dig [DIGITS];
  logic [DIGITS-1:0] w_is_max;
  logic [DIGITS-1:0] w_is_zero;
  logic [DIGITS-1:0] w_lo_max;
  logic [DIGITS-1:0] w_lo_zero;
  logic              w_full_max;
  logic              w_full_zero;
  logic              w_term;
  logic              w_wrap;
  logic              w_sat_hit;
  logic              w_move;
  logic              r_carry;
  logic              r_borrow;
  logic              r_sat;

  // Out-of-range load digits are rejected and replaced by zero.
  function automatic logic [3:0] f_sanitize(input logic [3:0] d);
    return ({1'b0, d} < MODW) ? d : 4'd0;
  endfunction

  for (genvar i = 0; i < DIGITS; i++) begin : g_dig
    assign w_is_max[i]  = (r_dig[i] == DMAX);
    assign w_is_zero[i] = (r_dig[i] == 4'd0);
    assign w_ld_dig[i]  = f_sanitize(load_val[4*i +: 4]);
    assign cnt[4*i +: 4] = r_dig[i];
  end

  // Lookahead enables: digit i steps when every lower digit is terminal.
  always_comb begin
    logic m;
    logic z;
    m = 1'b1;
    z = 1'b1;
    w_lo_max  = '0;
    w_lo_zero = '0;
    for (int i = 0; i < DIGITS; i++) begin
      w_lo_max[i]  = m;
      w_lo_zero[i] = z;
      m = m & w_is_max[i];
      z = z & w_is_zero[i];
    end
    w_full_max  = m;
    w_full_zero = z;
  end

  assign w_term    = up ? w_full_max : w_full_zero;
  assign w_wrap    = en & w_term & WRAP;
  assign w_sat_hit = en & w_term & ~WRAP;
  assign w_move    = en & ~w_sat_hit;
  assign tc        = en & w_term;

  // Per-digit next value for a counting step.
  always_comb begin
    for (int i = 0; i < DIGITS; i++) begin
      w_dig_nxt[i] = r_dig[i];
      if (w_move) begin
        if (up && w_lo_max[i]) begin
          w_dig_nxt[i] = w_is_max[i] ? 4'd0 : r_dig[i] + 4'd1;
        end else if (!up && w_lo_zero[i]) begin
          w_dig_nxt[i] = w_is_zero[i] ? DMAX : r_dig[i] - 4'd1;
        end
      end
    end
  end

  // Digit registers with clr > load > en priority.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < DIGITS; i++) r_dig[i] <= 4'd0;
    end else if (clr) begin
      for (int i = 0; i < DIGITS; i++) r_dig[i] <= 4'd0;
    end else if (load) begin
      for (int i = 0; i < DIGITS; i++) r_dig[i] <= w_ld_dig[i];
    end else begin
      for (int i = 0; i < DIGITS; i++) r_dig[i] <= w_dig_nxt[i];
    end
  end

  // Wrap pulses and the saturation flag.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_carry  <= 1'b0;
      r_borrow <= 1'b0;
      r_sat    <= 1'b0;
    end else if (clr || load) begin
      r_carry  <= 1'b0;
      r_borrow <= 1'b0;
      r_sat    <= 1'b0;
    end else begin
      r_carry  <= w_wrap & up;
      r_borrow <= w_wrap & ~up;
      if (w_sat_hit) begin
        r_sat <= 1'b1;
      end else if (en) begin
        r_sat <= 1'b0;
      end
    end
  end

  assign carry  = r_carry;
  assign borrow = r_borrow;
  assign sat    = r_sat;

endmodule

// File: tb/tb_bcd_cascade_counter.sv
// Randomised bench for bcd_cascade_counter against an arithmetic model.
// Three instances: base-10 wrap, base-10 saturate, base-16 wrap.
module tb_bcd_cascade_counter;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        en = 1'b0;
  logic        up = 1'b1;
  logic        clr = 1'b0;
  logic        load = 1'b0;
  logic [15:0] lv = 16'h0;

  logic [15:0] cnt_o [3];
  logic [2:0]  carry_o;
  logic [2:0]  borrow_o;
  logic [2:0]  tc_o;
  logic [2:0]  sat_o;

  int n_tests = 0;
  int n_fail = 0;

  int MODS [3] = '{10, 10, 16};
  bit WRS  [3] = '{1'b1, 1'b0, 1'b1};
  int mv [3];
  bit mc [3];
  bit mb [3];
  bit ms [3];

  always #5 clk = ~clk;

  bcd_cascade_counter #(.DIGITS(4), .MODULUS(10), .WRAP(1'b1)) u_a (
    .clk(clk), .rst(rst), .en(en), .up(up), .clr(clr), .load(load),
    .load_val(lv), .cnt(cnt_o[0]), .carry(carry_o[0]),
    .borrow(borrow_o[0]), .tc(tc_o[0]), .sat(sat_o[0])
  );

  bcd_cascade_counter #(.DIGITS(4), .MODULUS(10), .WRAP(1'b0)) u_s (
    .clk(clk), .rst(rst), .en(en), .up(up), .clr(clr), .load(load),
    .load_val(lv), .cnt(cnt_o[1]), .carry(carry_o[1]),
    .borrow(borrow_o[1]), .tc(tc_o[1]), .sat(sat_o[1])
  );

  bcd_cascade_counter #(.DIGITS(4), .MODULUS(16), .WRAP(1'b1)) u_h (
    .clk(clk), .rst(rst), .en(en), .up(up), .clr(clr), .load(load),
    .load_val(lv), .cnt(cnt_o[2]), .carry(carry_o[2]),
    .borrow(borrow_o[2]), .tc(tc_o[2]), .sat(sat_o[2])
  );

  function automatic int pw(input int m, input int e);
    int r = 1;
    for (int i = 0; i < e; i++) r = r * m;
    return r;
  endfunction

  function automatic int top_val(input int k);
    return pw(MODS[k], 4) - 1;
  endfunction

  function automatic logic [15:0] pack(input int k, input int v);
    logic [15:0] r;
    r = '0;
    for (int i = 0; i < 4; i++)
      r[4*i +: 4] = 4'((v / pw(MODS[k], i)) % MODS[k]);
    return r;
  endfunction

  function automatic int load_num(input int k, input logic [15:0] x);
    int v = 0;
    for (int i = 0; i < 4; i++) begin
      int d;
      d = int'(x[4*i +: 4]);
      if (d >= MODS[k]) d = 0;
      v = v + d * pw(MODS[k], i);
    end
    return v;
  endfunction

  task automatic model_reset();
    for (int k = 0; k < 3; k++) begin
      mv[k] = 0; mc[k] = 0; mb[k] = 0; ms[k] = 0;
    end
  endtask

  task automatic model_step();
    for (int k = 0; k < 3; k++) begin
      int mx;
      mx = top_val(k);
      if (!rst) begin
        mv[k] = 0; mc[k] = 0; mb[k] = 0; ms[k] = 0;
      end else if (clr) begin
        mv[k] = 0; mc[k] = 0; mb[k] = 0; ms[k] = 0;
      end else if (load) begin
        mv[k] = load_num(k, lv); mc[k] = 0; mb[k] = 0; ms[k] = 0;
      end else if (en) begin
        mc[k] = 0; mb[k] = 0;
        if (up && mv[k] == mx) begin
          if (WRS[k]) begin mv[k] = 0; mc[k] = 1; end
          else ms[k] = 1;
        end else if (!up && mv[k] == 0) begin
          if (WRS[k]) begin mv[k] = mx; mb[k] = 1; end
          else ms[k] = 1;
        end else begin
          mv[k] = up ? mv[k] + 1 : mv[k] - 1;
          ms[k] = 0;
        end
      end else begin
        mc[k] = 0; mb[k] = 0;
      end
    end
  endtask

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s actual=%h required=%h t=%0t", nm, act, exp, $time);
    end
  endtask

  task automatic check_all();
    for (int k = 0; k < 3; k++) begin
      bit etc;
      etc = en && (up ? (mv[k] == top_val(k)) : (mv[k] == 0));
      chk($sformatf("cnt%0d", k), 32'(cnt_o[k]), 32'(pack(k, mv[k])));
      chk($sformatf("carry%0d", k), 32'(carry_o[k]), 32'(mc[k]));
      chk($sformatf("borrow%0d", k), 32'(borrow_o[k]), 32'(mb[k]));
      chk($sformatf("sat%0d", k), 32'(sat_o[k]), 32'(ms[k]));
      chk($sformatf("tc%0d", k), 32'(tc_o[k]), 32'(etc));
    end
  endtask

  task automatic tick();
    @(posedge clk);
    model_step();
    @(negedge clk);
    check_all();
  endtask

  task automatic drive(input bit c, input bit l, input bit e,
                       input bit u, input logic [15:0] v);
    clr = c; load = l; en = e; up = u; lv = v;
  endtask

  logic [15:0] picks [6] = '{16'h9999, 16'h9998, 16'h0000,
                             16'h0001, 16'hFFFF, 16'h1A3F};

  initial begin
    model_reset();
    rst = 1'b0;
    drive(0, 0, 1, 1, 16'h0);
    repeat (3) tick();
    chk("rst_cnt", 32'(cnt_o[0]), 32'h0);
    chk("rst_flags", 32'({carry_o[0], borrow_o[0], sat_o[0]}), 32'h0);
    rst = 1'b1;
    repeat (12) tick();
    chk("count12", 32'(cnt_o[0]), 32'h0012);

    drive(0, 1, 0, 1, 16'h9998); tick();
    drive(0, 0, 1, 1, 16'h0); tick();
    chk("upw_9999", 32'(cnt_o[0]), 32'h9999);
    chk("upw_tc", 32'(tc_o[0]), 32'h1);
    tick();
    chk("upw_0000", 32'(cnt_o[0]), 32'h0000);
    chk("upw_carry", 32'(carry_o[0]), 32'h1);
    tick();
    chk("upw_0001", 32'(cnt_o[0]), 32'h0001);
    chk("upw_carry_off", 32'(carry_o[0]), 32'h0);

    drive(0, 1, 0, 0, 16'h0001); tick();
    drive(0, 0, 1, 0, 16'h0); tick();
    chk("dnw_0000", 32'(cnt_o[0]), 32'h0000);
    chk("dnw_tc", 32'(tc_o[0]), 32'h1);
    tick();
    chk("dnw_9999", 32'(cnt_o[0]), 32'h9999);
    chk("dnw_borrow", 32'(borrow_o[0]), 32'h1);
    tick();
    chk("dnw_borrow_off", 32'(borrow_o[0]), 32'h0);

    drive(0, 1, 0, 1, 16'h9999); tick();
    drive(0, 0, 1, 1, 16'h0); repeat (3) tick();
    chk("sat_cnt", 32'(cnt_o[1]), 32'h9999);
    chk("sat_carry", 32'(carry_o[1]), 32'h0);
    chk("sat_flag", 32'(sat_o[1]), 32'h1);
    drive(0, 0, 1, 0, 16'h0); tick();
    chk("sat_rel_cnt", 32'(cnt_o[1]), 32'h9998);
    chk("sat_rel_flag", 32'(sat_o[1]), 32'h0);

    drive(1, 1, 1, 1, 16'h1234); tick();
    chk("prio_clr", 32'(cnt_o[0]), 32'h0);
    drive(0, 1, 0, 1, 16'h1A3F); tick();
    chk("ld_sanit", 32'(cnt_o[0]), 32'h1030);
    chk("ld_hex", 32'(cnt_o[2]), 32'h1A3F);
    drive(0, 1, 0, 1, 16'hFFFF); tick();
    drive(0, 0, 1, 1, 16'h0); tick();
    chk("hex_wrap", 32'(cnt_o[2]), 32'h0000);
    chk("hex_carry", 32'(carry_o[2]), 32'h1);

    drive(0, 1, 0, 1, 16'h0456); tick();
    drive(0, 0, 1, 1, 16'h0); tick();
    chk("pre_async", 32'(cnt_o[0]), 32'h0457);
    #2 rst = 1'b0;
    #1;
    chk("async_cnt", 32'(cnt_o[0]), 32'h0);
    chk("async_carry", 32'(carry_o[0]), 32'h0);
    model_reset();
    tick();
    rst = 1'b1;
    tick();

    for (int n = 0; n < 3000; n++) begin
      int r;
      logic [15:0] v;
      r = int'($urandom_range(0, 99));
      if ($urandom_range(0, 5) < 3) v = picks[$urandom_range(0, 5)];
      else v = 16'($urandom);
      if (($urandom_range(0, 7)) == 0) up = ~up;
      if (r < 2) drive(1, $urandom_range(0, 1) == 1, 1'b1, up, v);
      else if (r < 8) drive(0, 1, $urandom_range(0, 1) == 1, up, v);
      else if (r < 85) drive(0, 0, 1, up, v);
      else drive(0, 0, 0, up, v);
      if (r == 99) rst = 1'b0;
      else rst = 1'b1;
      tick();
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
